// File: rtl/frequency_sweep_controller.sv
// Frequency sweep sequencer: steps phase_step over a range and reports filter peak-to-peak per point.
// Optional FREQUENCY_SWEEP_AUTO_REPEAT_EN adds repeat_enable to restart the sweep at each finish.
module frequency_sweep_controller #(
    parameter int PHASE_STEP_WIDTH = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic [PHASE_STEP_WIDTH-1:0]        start_step,
    input  logic [PHASE_STEP_WIDTH-1:0]        stop_step,
    input  logic [PHASE_STEP_WIDTH-1:0]        step_increment,
    input  logic [COUNT_WIDTH-1:0]             settle_cycles,
    input  logic [COUNT_WIDTH-1:0]             dwell_cycles,
    input  logic signed [DATA_WIDTH-1:0]       filtered_data,
    output logic [PHASE_STEP_WIDTH-1:0]        phase_step,
    output logic                               busy,
    output logic                               done,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [PHASE_STEP_WIDTH-1:0]        result_step,
    output logic [DATA_WIDTH:0]                result_p2p
`ifdef FREQUENCY_SWEEP_AUTO_REPEAT_EN
    ,
    input  logic                               repeat_enable
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] REPORT  = 2'd3;

    logic [1:0]                    state;
    logic [PHASE_STEP_WIDTH-1:0]   start_lat;
    logic [PHASE_STEP_WIDTH-1:0]   stop_lat;
    logic [PHASE_STEP_WIDTH-1:0]   inc_lat;
    logic [COUNT_WIDTH-1:0]        settle_lat;
    logic [COUNT_WIDTH-1:0]        dwell_lat;
    logic [COUNT_WIDTH-1:0]        count;
    logic signed [DATA_WIDTH-1:0]  max_val;
    logic signed [DATA_WIDTH-1:0]  min_val;
    logic                          first_sample;
    logic                          repeat_now;
    logic [COUNT_WIDTH:0]          count_next;
    logic [PHASE_STEP_WIDTH:0]     next_step;
    logic                          finish;
    logic [DATA_WIDTH:0]           p2p;

`ifdef FREQUENCY_SWEEP_AUTO_REPEAT_EN
    assign repeat_now = repeat_enable;
`else
    assign repeat_now = 1'b0;
`endif

    // A zero-length window still lasts one cycle, since count_next starts at 1.
    assign count_next = {1'b0, count} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign next_step  = {1'b0, phase_step} + {1'b0, inc_lat};
    assign finish     = next_step[PHASE_STEP_WIDTH]
                     || (next_step[PHASE_STEP_WIDTH-1:0] > stop_lat)
                     || (inc_lat == '0);
    // Sign-extended difference cannot overflow DATA_WIDTH+1 bits.
    assign p2p = {max_val[DATA_WIDTH-1], max_val} - {min_val[DATA_WIDTH-1], min_val};

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            phase_step   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result_step  <= '0;
            result_p2p   <= '0;
            start_lat    <= '0;
            stop_lat     <= '0;
            inc_lat      <= '0;
            settle_lat   <= '0;
            dwell_lat    <= '0;
            count        <= '0;
            max_val      <= '0;
            min_val      <= '0;
            first_sample <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                busy         <= 1'b0;
                result_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            start_lat  <= start_step;
                            stop_lat   <= stop_step;
                            inc_lat    <= step_increment;
                            settle_lat <= settle_cycles;
                            dwell_lat  <= dwell_cycles;
                            phase_step <= start_step;
                            busy       <= 1'b1;
                            count      <= '0;
                            state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (count_next >= {1'b0, settle_lat}) begin
                            count        <= '0;
                            first_sample <= 1'b1;
                            state        <= MEASURE;
                        end else begin
                            count <= count_next[COUNT_WIDTH-1:0];
                        end
                    end
                    MEASURE: begin
                        first_sample <= 1'b0;
                        if (first_sample || (filtered_data > max_val)) begin
                            max_val <= filtered_data;
                        end
                        if (first_sample || (filtered_data < min_val)) begin
                            min_val <= filtered_data;
                        end
                        if (count_next >= {1'b0, dwell_lat}) begin
                            count <= '0;
                            state <= REPORT;
                        end else begin
                            count <= count_next[COUNT_WIDTH-1:0];
                        end
                    end
                    REPORT: begin
                        // First REPORT cycle publishes the result; it then waits for the consumer.
                        if (!result_valid) begin
                            result_valid <= 1'b1;
                            result_step  <= phase_step;
                            result_p2p   <= p2p;
                        end else if (result_ready) begin
                            result_valid <= 1'b0;
                            if (finish) begin
                                done <= 1'b1;
                                if (repeat_now) begin
                                    phase_step <= start_lat;
                                    state      <= SETTLE;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end else begin
                                phase_step <= next_step[PHASE_STEP_WIDTH-1:0];
                                state      <= SETTLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frequency_sweep_controller.sv
// Self-checking bench for frequency_sweep_controller: randomized sweeps against a point-list model.
// Exercises the repeat feature only when FREQUENCY_SWEEP_AUTO_REPEAT_EN is defined.
module tb_frequency_sweep_controller;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] start_step;
    logic [31:0] stop_step;
    logic [31:0] step_increment;
    logic [15:0] settle_cycles;
    logic [15:0] dwell_cycles;
    logic [31:0] filtered_data;
    logic [31:0] phase_step;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_step;
    logic [32:0] result_p2p;
    logic        repeat_enable;

    int total = 0;
    int bad   = 0;

    frequency_sweep_controller #(
        .PHASE_STEP_WIDTH(32),
        .DATA_WIDTH(32),
        .COUNT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .start_step(start_step),
        .stop_step(stop_step),
        .step_increment(step_increment),
        .settle_cycles(settle_cycles),
        .dwell_cycles(dwell_cycles),
        .filtered_data(filtered_data),
        .phase_step(phase_step),
        .busy(busy),
        .done(done),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_step(result_step),
        .result_p2p(result_p2p)
`ifdef FREQUENCY_SWEEP_AUTO_REPEAT_EN
        ,
        .repeat_enable(repeat_enable)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Value driven on measurement cycle k for a given data pattern.
    function automatic logic [31:0] gen(input int mode, input int k);
        case (mode)
            0:       return 32'h0000_1234;
            1:       return (k % 2 == 1) ? 32'd1000 : -32'sd3000;
            2:       return (k % 2 == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic scrambleConfig();
        start          = 1'($urandom_range(0, 1));
        start_step     = $urandom;
        stop_step      = $urandom;
        step_increment = $urandom;
        settle_cycles  = 16'($urandom);
        dwell_cycles   = 16'($urandom);
    endtask

    // Runs one sweep from the start edge to its completion (or to an abort at point abort_pt).
    task automatic applyStimulus(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] inc,
                                 input int sc, input int dc, input int mode, input int hold,
                                 input int passes, input int abort_pt);
        logic [31:0] steps[$];
        longint unsigned cur;
        int s_eff, d_eff, last;
        longint mx, mn, v, exp_p2p;
        logic [31:0] drv;

        // Reference point list: step from start while the running value stays at or below stop.
        steps = {};
        cur = longint'(st);
        while (1) begin
            steps.push_back(cur[31:0]);
            cur = cur + longint'(inc);
            if (inc == 0 || cur > longint'(sp) || steps.size() >= 64) break;
        end
        last  = steps.size() - 1;
        s_eff = (sc == 0) ? 1 : sc;
        d_eff = (dc == 0) ? 1 : dc;

        start_step     = st;
        stop_step      = sp;
        step_increment = inc;
        settle_cycles  = 16'(sc);
        dwell_cycles   = 16'(dc);
        start          = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        checkOutput("step_after_start", 64'(phase_step), 64'(st));

        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i <= last; i++) begin
                mx = 0;
                mn = 0;
                for (int k = 1; k <= s_eff + d_eff + 1; k++) begin
                    if (k > s_eff && k <= s_eff + d_eff) begin
                        drv = gen(mode, k);
                        v = longint'($signed(drv));
                        if (k == s_eff + 1) begin
                            mx = v;
                            mn = v;
                        end else begin
                            if (v > mx) mx = v;
                            if (v < mn) mn = v;
                        end
                    end else begin
                        drv = (mode == 0) ? gen(0, k) : $urandom;
                    end
                    filtered_data = drv;
                    result_ready  = (hold == 0);
                    scrambleConfig();
                    tick();
                    if (k == s_eff + d_eff) checkOutput("valid_early", 64'(result_valid), 64'd0);
                end
                start = 1'b0;
                exp_p2p = mx - mn;
                checkOutput("valid_rise", 64'(result_valid), 64'd1);
                checkOutput("result_step", 64'(result_step), 64'(steps[i]));
                checkOutput("result_p2p", 64'(result_p2p), 64'(exp_p2p));

                for (int h = 0; h < hold; h++) begin
                    filtered_data = $urandom;
                    tick();
                    checkOutput("hold_valid", 64'(result_valid), 64'd1);
                    checkOutput("hold_step", 64'(result_step), 64'(steps[i]));
                    checkOutput("hold_p2p", 64'(result_p2p), 64'(exp_p2p));
                    checkOutput("hold_phase", 64'(phase_step), 64'(steps[i]));
                end

                if (i == abort_pt) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    checkOutput("abort_valid", 64'(result_valid), 64'd0);
                    checkOutput("abort_busy", 64'(busy), 64'd0);
                    checkOutput("abort_done", 64'(done), 64'd0);
                    checkOutput("abort_phase", 64'(phase_step), 64'(steps[i]));
                    tick();
                    checkOutput("abort_done_later", 64'(done), 64'd0);
                    return;
                end

                result_ready  = 1'b1;
                repeat_enable = (p < passes - 1);
                tick();
                result_ready  = 1'b0;
                checkOutput("valid_cleared", 64'(result_valid), 64'd0);
                if (i == last) begin
                    checkOutput("done_pulse", 64'(done), 64'd1);
                    if (p < passes - 1) begin
                        checkOutput("repeat_busy", 64'(busy), 64'd1);
                        checkOutput("repeat_phase", 64'(phase_step), 64'(st));
                    end else begin
                        checkOutput("final_busy", 64'(busy), 64'd0);
                        checkOutput("final_phase", 64'(phase_step), 64'(steps[i]));
                    end
                end else begin
                    checkOutput("mid_done", 64'(done), 64'd0);
                    checkOutput("next_phase", 64'(phase_step), 64'(steps[i+1]));
                end
            end
        end
        repeat_enable = 1'b0;
        tick();
        checkOutput("done_one_cycle", 64'(done), 64'd0);
        checkOutput("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_phase"}, 64'(phase_step), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_valid"}, 64'(result_valid), 64'd0);
        checkOutput({tag, "_rstep"}, 64'(result_step), 64'd0);
        checkOutput({tag, "_p2p"}, 64'(result_p2p), 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        longint unsigned sp64;
        logic [31:0] rs, ri;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start_step = '0;
        stop_step = '0;
        step_increment = '0;
        settle_cycles = '0;
        dwell_cycles = '0;
        filtered_data = '0;
        result_ready = 1'b0;
        repeat_enable = 1'b0;
        repeat (3) tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        applyStimulus(32'h000F_FFFF, 32'h002F_FFFF, 32'h0010_0000, 10, 20, 0, 0, 1, -1);
        applyStimulus(32'h0000_0100, 32'h0000_0100, 32'h0000_0010, 3, 8, 1, 0, 1, -1);
        applyStimulus(32'h0000_0200, 32'h0000_0300, 32'h0000_0100, 2, 6, 2, 1, 1, -1);
        applyStimulus(32'hFFF0_0000, 32'hFFFF_FFFF, 32'h0020_0000, 4, 5, 3, 0, 1, -1);
        applyStimulus(32'h0000_5000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 3, 3, 0, 1, -1);
        applyStimulus(32'h0090_0000, 32'h0010_0000, 32'h0001_0000, 2, 2, 3, 0, 1, -1);
        applyStimulus(32'h0000_0040, 32'h0000_0060, 32'h0000_0010, 0, 0, 3, 2, 1, -1);
        applyStimulus(32'h0000_0100, 32'h0000_1000, 32'h0000_0100, 3, 4, 3, 50, 1, 0);

        // Reset in the middle of MEASURE, then a normal sweep.
        start_step = 32'h0000_ABCD;
        stop_step = 32'hFFFF_FFFF;
        step_increment = 32'h10;
        settle_cycles = 16'd2;
        dwell_cycles = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) begin
            filtered_data = $urandom;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkResetValues("midreset");
        applyStimulus(32'h0000_0010, 32'h0000_0030, 32'h0000_0010, 2, 3, 3, 0, 1, -1);

        // start together with abort in IDLE keeps the controller idle.
        held = phase_step;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", 64'(busy), 64'd0);
        checkOutput("start_abort_phase", 64'(phase_step), 64'(held));

        for (int r = 0; r < 8; r++) begin
            rs = $urandom;
            ri = ($urandom_range(0, 4) == 0) ? 32'd0 : (32'($urandom_range(1, 16)) << 16);
            sp64 = longint'(rs) + longint'(ri) * longint'($urandom_range(0, 3)) + longint'($urandom_range(0, 15));
            if (sp64 > 64'hFFFF_FFFF) sp64 = 64'hFFFF_FFFF;
            applyStimulus(rs, sp64[31:0], ri, $urandom_range(0, 4), $urandom_range(0, 6), 3,
                          $urandom_range(0, 3), 1, -1);
        end

`ifdef FREQUENCY_SWEEP_AUTO_REPEAT_EN
        applyStimulus(32'h0000_1000, 32'h0000_1100, 32'h0000_0100, 2, 3, 3, 0, 3, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
